// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller slice.
// Money is counted in half-yuan units throughout.
package vend_pkg;

    localparam int MONEY_W = 8;

    localparam logic [MONEY_W-1:0] ONE_YUAN = 8'd2;
    localparam logic [MONEY_W-1:0] TEN_YUAN = 8'd20;

    localparam logic [MONEY_W-1:0] PRICE0_DEF = 8'd5;
    localparam logic [MONEY_W-1:0] PRICE1_DEF = 8'd7;
    localparam logic [MONEY_W-1:0] PRICE2_DEF = 8'd10;
    localparam logic [MONEY_W-1:0] PRICE3_DEF = TEN_YUAN + (TEN_YUAN >> 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOCK,
        S_CHECK,
        S_VEND,
        S_CHANGE,
        S_CLEAR
    } state_t;

    // Amount paid out by the next change pulse: a whole yuan when possible.
    function automatic logic [MONEY_W-1:0] coin_value(input logic [MONEY_W-1:0] rem);
        if (rem >= ONE_YUAN) begin
            return ONE_YUAN;
        end
        return rem;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Change payout pacer: loads an amount, then alternates one coin-pulse cycle
// with one gap cycle until the amount is exhausted, flagging done in the final gap.
module vend_change_gen
    import vend_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [MONEY_W-1:0] load_val,
    input  logic               run,
    output logic               chg_one,
    output logic               chg_half,
    output logic               done
);

    logic [MONEY_W-1:0] rem;
    logic               gap;
    logic [MONEY_W-1:0] src;
    logic               fire;

    // The load edge already registers the first pulse, so no dead cycle on entry.
    always_comb begin
        src  = load ? load_val : rem;
        fire = load || (run && gap && (rem != '0));
    end

    assign done = run && gap && (rem == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            gap      <= 1'b0;
            chg_one  <= 1'b0;
            chg_half <= 1'b0;
        end else if (fire) begin
            rem      <= src - coin_value(src);
            gap      <= 1'b0;
            chg_one  <= (src >= ONE_YUAN);
            chg_half <= (src == 8'd1);
        end else begin
            gap      <= run;
            chg_one  <= 1'b0;
            chg_half <= 1'b0;
        end
    end

endmodule

// File: rtl/vend_controller.sv
// Purchase/refund sequencer above the coin accumulator: lock, price check, vend, change, clear.
// Optional idle auto-refund is compiled in with `define VEND_TIMEOUT_EN.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [MONEY_W-1:0] PRICE0  = PRICE0_DEF,
    parameter logic [MONEY_W-1:0] PRICE1  = PRICE1_DEF,
    parameter logic [MONEY_W-1:0] PRICE2  = PRICE2_DEF,
    parameter logic [MONEY_W-1:0] PRICE3  = PRICE3_DEF,
    parameter int                 TIMEOUT = 1000
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MONEY_W-1:0] moneyv,
    input  logic               sel_valid,
    input  logic [1:0]         sel_item,
    input  logic               cancel,
    input  logic               vend_ack,
    output logic               acc_lock,
    output logic               acc_clr,
    output logic               vend_pulse,
    output logic [1:0]         vend_item,
    output logic               chg_one,
    output logic               chg_half,
    output logic               short_pulse,
    output logic               busy,
    output state_t             dbg_state
);

    state_t             state, next;
    logic [MONEY_W-1:0] rem, rem_n;
    logic [1:0]         item, item_n;
    logic [MONEY_W-1:0] price;
    logic               refund_req;
    logic               short_n;
    logic               chg_load;
    logic [MONEY_W-1:0] chg_val;
    logic               chg_done;
    logic               tmo_hit;

    assign dbg_state = state;

    always_comb begin
        case (item)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            default: price = PRICE3;
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0]   tmo_cnt;
    logic [MONEY_W-1:0] money_prev;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT));

    // Counts only undisturbed idle cycles holding credit; any activity restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt    <= '0;
            money_prev <= '0;
        end else begin
            money_prev <= moneyv;
            if (state != S_IDLE || moneyv == '0 || moneyv != money_prev ||
                sel_valid || cancel || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    assign refund_req = (cancel || tmo_hit) && (moneyv != '0);

    // Handshake: vend_pulse/vend_item stay asserted until vend_ack is sampled high
    // on a rising edge; vend_pulse falls in the following cycle.
    always_comb begin
        next     = state;
        rem_n    = rem;
        item_n   = item;
        short_n  = 1'b0;
        chg_load = 1'b0;
        chg_val  = rem;
        case (state)
            S_IDLE: begin
                if (refund_req) begin
                    rem_n    = moneyv;
                    chg_val  = moneyv;
                    chg_load = 1'b1;
                    next     = S_CHANGE;
                end else if (sel_valid) begin
                    item_n = sel_item;
                    next   = S_LOCK;
                end
            end
            S_LOCK:  next = S_CHECK;
            S_CHECK: begin
                if (moneyv >= price) begin
                    rem_n = moneyv - price;
                    next  = S_VEND;
                end else begin
                    short_n = 1'b1;
                    next    = S_IDLE;
                end
            end
            S_VEND: begin
                if (vend_ack) begin
                    if (rem == '0) begin
                        next = S_CLEAR;
                    end else begin
                        chg_load = 1'b1;
                        next     = S_CHANGE;
                    end
                end
            end
            S_CHANGE: begin
                if (chg_done) begin
                    next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rem_n = '0;
                next  = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rem         <= '0;
            item        <= 2'd0;
            acc_lock    <= 1'b0;
            busy        <= 1'b0;
            acc_clr     <= 1'b0;
            vend_pulse  <= 1'b0;
            vend_item   <= 2'd0;
            short_pulse <= 1'b0;
        end else begin
            state       <= next;
            rem         <= rem_n;
            item        <= item_n;
            acc_lock    <= (next != S_IDLE);
            busy        <= (next != S_IDLE);
            acc_clr     <= (next == S_CLEAR);
            vend_pulse  <= (next == S_VEND);
            vend_item   <= (next == S_VEND) ? item_n : 2'd0;
            short_pulse <= short_n;
        end
    end

    vend_change_gen u_change (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (chg_load),
        .load_val (chg_val),
        .run      (state == S_CHANGE),
        .chg_one  (chg_one),
        .chg_half (chg_half),
        .done     (chg_done)
    );

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model queues expected
// output events, and a negedge monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_vend_controller;
    import vend_pkg::*;

    localparam int         EV_W    = 12;
    localparam logic [3:0] T_VEND  = 4'd1;
    localparam logic [3:0] T_ONE   = 4'd2;
    localparam logic [3:0] T_HALF  = 4'd3;
    localparam logic [3:0] T_SHORT = 4'd4;
    localparam logic [3:0] T_CLR   = 4'd5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] moneyv = 8'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       cancel = 1'b0;
    logic       vend_ack = 1'b0;
    logic       acc_lock, acc_clr, vend_pulse, chg_one, chg_half, short_pulse, busy;
    logic [1:0] vend_item;
    state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [EV_W-1:0] exp_q[$];
    int price_of[4] = '{5, 7, 10, 30};

    vend_controller #(.TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n), .moneyv(moneyv), .sel_valid(sel_valid),
        .sel_item(sel_item), .cancel(cancel), .vend_ack(vend_ack),
        .acc_lock(acc_lock), .acc_clr(acc_clr), .vend_pulse(vend_pulse),
        .vend_item(vend_item), .chg_one(chg_one), .chg_half(chg_half),
        .short_pulse(short_pulse), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model(input int money, input bit sel, input int item, input bit cxl,
                         output bit vends, output int change);
        int rem;
        vends  = 1'b0;
        change = 0;
        if (cxl && money != 0) begin
            rem = money;
        end else if (sel) begin
            if (money >= price_of[item]) begin
                exp_q.push_back({T_VEND, 8'(item)});
                vends = 1'b1;
                rem   = money - price_of[item];
            end else begin
                exp_q.push_back({T_SHORT, 8'd0});
                return;
            end
        end else begin
            return;
        end
        change = rem;
        repeat (rem / 2) exp_q.push_back({T_ONE, 8'd0});
        if (rem % 2 == 1) exp_q.push_back({T_HALF, 8'd0});
        exp_q.push_back({T_CLR, 8'd0});
    endtask

    // ---------------- scoreboard monitor ----------------
    logic vend_prev = 1'b0;
    bit   prev_chg = 1'b0;
    int   last_chg = 0;

    task automatic got(input logic [EV_W-1:0] ev);
        logic [EV_W-1:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_event: got=%h required=none (cycle %0d)", ev, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e !== ev) begin
                n_errors++;
                $display("FAIL event: got=%h required=%h (cycle %0d)", ev, e, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_chg  = 1'b0;
            vend_prev = 1'b0;
        end else begin
            if (chg_one || chg_half) begin
                if (prev_chg) begin
                    n_checks++;
                    if (cyc - last_chg != 2) begin
                        n_errors++;
                        $display("FAIL chg_spacing: got=%0d required=2", cyc - last_chg);
                    end
                end
                prev_chg = 1'b1;
                last_chg = cyc;
            end else if (acc_clr || short_pulse || (vend_pulse && !vend_prev)) begin
                prev_chg = 1'b0;
            end
            if (chg_one)                 got({T_ONE, 8'd0});
            if (chg_half)                got({T_HALF, 8'd0});
            if (vend_pulse && !vend_prev) got({T_VEND, 6'd0, vend_item});
            if (short_pulse)             got({T_SHORT, 8'd0});
            if (acc_clr)                 got({T_CLR, 8'd0});
            vend_prev = vend_pulse;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_bit(input string name, input logic actual, input logic req);
        n_checks++;
        if (actual !== req) begin
            n_errors++;
            $display("FAIL %s: got=%b required=%b", name, actual, req);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [8:0] outs;
        outs = {acc_lock, acc_clr, vend_pulse, vend_item, chg_one, chg_half, short_pulse, busy};
        n_checks++;
        if (outs !== 9'd0 || dbg_state !== S_IDLE) begin
            n_errors++;
            $display("FAIL %s: outputs=%b state=%0d required outputs=0 state=IDLE",
                     name, outs, dbg_state);
        end
    endtask

    task automatic run_txn(input int money, input bit sel, input int item, input bit cxl,
                           input int ack_dly);
        bit vends;
        int change;
        int n;
        model(money, sel, item, cxl, vends, change);
        @(negedge clk);
        moneyv    = 8'(money);
        sel_valid = sel;
        sel_item  = 2'(item);
        cancel    = cxl;
        @(negedge clk);
        sel_valid = 1'b0;
        cancel    = 1'b0;
        if (vends) begin
            n = 1;
            while (!vend_pulse && n < 20) begin
                @(negedge clk);
                n++;
            end
            n_checks++;
            if (n != 3) begin
                n_errors++;
                $display("FAIL vend_latency: got=%0d required=3 cycles", n);
            end
            check_bit("lock_in_vend", acc_lock, 1'b1);
            repeat (ack_dly) @(negedge clk);
            vend_ack = 1'b1;
            @(negedge clk);
            vend_ack = 1'b0;
            check_bit("vend_drop_after_ack", vend_pulse, 1'b0);
            if (change == 0) check_bit("clr_after_ack", acc_clr, 1'b1);
        end
        n = 0;
        while (busy && n < 800) begin
            @(negedge clk);
            n++;
        end
        if (n >= 800) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy still high after %0d cycles, required idle", n);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drained: got=%0d pending events required=0", exp_q.size());
            exp_q.delete();
        end
        check_bit("idle_lock", acc_lock, 1'b0);
        check_bit("idle_busy", busy, 1'b0);
        moneyv = 8'd0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset_idle");

        run_txn(20, 1'b1, 1, 1'b0, 3);   // change 13: six whole, one half
        run_txn(5, 1'b1, 0, 1'b0, 0);    // exact price
        run_txn(4, 1'b1, 2, 1'b0, 0);    // short
        run_txn(6, 1'b1, 0, 1'b1, 0);    // cancel beats select
        run_txn(0, 1'b0, 0, 1'b1, 0);    // cancel with no credit ignored
        run_txn(29, 1'b1, 3, 1'b0, 0);   // one below price
        run_txn(30, 1'b1, 3, 1'b0, 2);   // exactly price
        run_txn(8, 1'b1, 0, 1'b0, 1);    // change 3: one whole, one half
        run_txn(1, 1'b0, 0, 1'b1, 0);    // half-yuan refund
        run_txn(255, 1'b1, 0, 1'b0, 4);  // maximum credit

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 40), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4));
        end

        // Reset in the middle of a refund with 8 half-units still owed.
        exp_q.push_back({T_ONE, 8'd0});
        exp_q.push_back({T_ONE, 8'd0});
        @(negedge clk);
        moneyv = 8'd12;
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (n >= 20) begin
            n_errors++;
            $display("FAIL refund_start: got %0d pending pulses required 0", exp_q.size());
        end
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset_mid_change");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        moneyv = 8'd0;
        repeat (20) @(negedge clk);
        check_all_zero("idle_after_reset");

        // Credit held while idle: auto-refund only when the timeout is compiled in.
        @(negedge clk);
        moneyv = 8'd2;
`ifdef VEND_TIMEOUT_EN
        exp_q.push_back({T_ONE, 8'd0});
        exp_q.push_back({T_CLR, 8'd0});
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        moneyv = 8'd0;
        n_checks++;
        if (n >= 40) begin
            n_errors++;
            $display("FAIL timeout_refund: no refund after %0d cycles, required one", n);
        end
        repeat (12) @(negedge clk);
`else
        repeat (40) @(negedge clk);
        check_bit("no_timeout_busy", busy, 1'b0);
        moneyv = 8'd0;
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL timeout_drained: got=%0d pending required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Sequencing controller for the vending datapath. It sits above the coin accumulator: it freezes the accumulator when a purchase is requested, compares the credit against the selected item's price, pulses the product vend strobe, and pays change as individually paced coin pulses. It then clears the accumulator through that block's synchronous clear input. All money values are in half-yuan units, matching the accumulator: one 1-yuan coin = 2, one 10-yuan note = 20.

## Interface
- PRICE0, 5: price of item 0 (half-yuan units, 8-bit)
- PRICE1, 7: price of item 1
- PRICE2, 10: price of item 2
- PRICE3, 30: price of item 3
- TIMEOUT, 1000: idle cycles before auto-refund (used only with VEND_TIMEOUT_EN)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- moneyv  input  8  current credit from accumulator
- sel_valid  input  1  purchase request, level, sampled in IDLE
- sel_item  input  2  item index, valid with sel_valid
- cancel  input  1  refund request, sampled in IDLE
- vend_ack  input  1  product mechanism done
- acc_lock  output  1  freezes accumulator crediting
- acc_clr  output  1  one-cycle synchronous clear to accumulator
- vend_pulse  output  1  held high until vend_ack
- vend_item  output  2  item being vended, valid while vend_pulse
- chg_one  output  1  one-cycle pulse = pay one 1-yuan coin
- chg_half  output  1  one-cycle pulse = pay one half-yuan coin
- short_pulse  output  1  one-cycle pulse: insufficient credit
- busy  output  1  state != IDLE

## Operation
- States: IDLE, LOCK, CHECK, VEND, CHANGE, CLEAR.
- IDLE: acc_lock=0.
  - cancel=1 and moneyv!=0: set rem=moneyv, go to CHANGE.
  - Otherwise, sel_valid=1: latch sel_item, go to LOCK.
  - cancel wins over a simultaneous sel_valid.
  - cancel with moneyv==0 is ignored.
- LOCK: acc_lock=1 for one settling cycle, so a coin edge in flight is absorbed. Always go to CHECK.
- CHECK: compare moneyv (8-bit unsigned) with price[item].
  - moneyv >= price: rem = moneyv - price, go to VEND.
  - Otherwise: short_pulse=1 for this cycle, return to IDLE (lock released, credit kept).
- VEND: vend_pulse=1 and vend_item held. On vend_ack: if rem==0 go to CLEAR, else go to CHANGE.
- CHANGE: alternates a pulse cycle and a gap cycle.
  - rem>=2: chg_one=1, rem-=2.
  - rem==1: chg_half=1, rem=0.
  - After the gap cycle that follows the last pulse (rem==0), go to CLEAR.
- CLEAR: acc_clr=1 for one cycle, then go to IDLE.
- acc_lock=1 in every state except IDLE.
- rem is 8-bit and never underflows: subtraction happens only when moneyv >= price.

## Timing
- Reset (rst_n low, async): state=IDLE; rem=0; latched item=0; every output 0.
- Reset mid-sequence aborts immediately. Any unpaid change is lost. The accumulator's own reset governs its credit.
- sel_valid to first possible vend_pulse: 3 cycles (IDLE→LOCK→CHECK→VEND registered).
- vend_ack sampled each cycle in VEND. vend_pulse drops in the cycle after ack is seen.
- Change rate: one coin pulse every 2 cycles. Refund of N half-units takes floor(N/2)+(N mod 2) pulses.
- acc_clr is asserted exactly once per completed vend or refund, never on a short.
- All outputs are registered.

## Configuration
- VEND_TIMEOUT_EN defined:
  - A counter runs in IDLE while moneyv!=0. It resets on any moneyv change, sel_valid, or cancel.
  - Reaching TIMEOUT behaves as cancel.
- VEND_TIMEOUT_EN undefined: no counter, no TIMEOUT logic; credit is held indefinitely.

## Structure
- Shared package vend_pkg holds:
  - the state enum;
  - MONEY_W=8;
  - half-unit constants ONE_YUAN=2 and TEN_YUAN=20;
  - default price constants.
- Natural sub-module: vend_change_gen. It loads rem, emits paced chg_one/chg_half, and signals done; the controller FSM instantiates it.

## Test plan
- moneyv=20, select item1 (price 7), ack after 3 cycles:
  - vend_pulse with vend_item=1;
  - then 6 chg_one pulses and 1 chg_half pulse, spaced 2 cycles;
  - then one acc_clr.
- moneyv=5, select item0 (price 5): vend, no change pulses, acc_clr in the cycle after the ack cycle.
- moneyv=4, select item2 (price 10): short_pulse once, back to IDLE, acc_lock=0, no acc_clr.
- moneyv=6, cancel and sel_valid in the same cycle: 3 chg_one pulses, acc_clr, no vend_pulse.
- rst_n low during CHANGE with rem=8: all outputs 0 asynchronously; IDLE on release; no further pulses.
- VEND_TIMEOUT_EN with TIMEOUT=10 and moneyv=2 held idle: after 10 cycles, 1 chg_one pulse then acc_clr. Without the macro: no action.
